// File: rtl/seq5_tracker.sv
// seq5_tracker: monitor for the 5-state T-flip-flop sequence counter.
// Decodes the code cycle 000->010->011->100->110->000 into position 0..4, checks every
// transition against the direction fed to the counter on the previous edge, counts signed
// revolutions and raises a sticky fault on any illegal code or unexpected step.
//
// Parameters: REV_W revolution counter width (wraps), ERR_W fault counter width (saturates).
// Ports:
//   clk_i      rising-edge clock          reset_i  async active-high reset
//   clr_i      sync clear to IDLE          x_i      direction fed to counter (0 fwd, 1 rev)
//   w_i[2:0]   counter state code          pos_o    decoded position
//   pos_vld_o  pos from a legal code       dir_o    direction of last checked transition
//   rev_o      signed revolution count     wrap_o   one-cycle revolution pulse
//   err_o      sticky fault                err_cnt_o saturating fault count
// Optional feature: define SEQ5_ERR_CNT_EN to build the err_cnt_o port and counter.
module seq5_tracker #(
    parameter int unsigned REV_W = 8,
    parameter int unsigned ERR_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             x_i,
    input  logic [2:0]       w_i,
    output logic [2:0]       pos_o,
    output logic             pos_vld_o,
    output logic             dir_o,
    output logic [REV_W-1:0] rev_o,
    output logic             wrap_o,
`ifdef SEQ5_ERR_CNT_EN
    output logic [ERR_W-1:0] err_cnt_o,
`endif
    output logic             err_o
);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    state_e           state_q, state_d;
    logic [2:0]       w_prev_q;
    logic             x_prev_q;
    logic [2:0]       pos_q, pos_d;
    logic             pos_vld_q, pos_vld_d;
    logic             dir_q, dir_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             cur_legal, prev_legal;
    logic [2:0]       cur_idx, prev_idx, exp_idx;
    logic             check_ok, wrap_fwd, wrap_rev;

    function automatic logic [3:0] decode(input logic [2:0] code);
        // Returns {legal, index}.
        case (code)
            3'b000:  decode = {1'b1, 3'd0};
            3'b010:  decode = {1'b1, 3'd1};
            3'b011:  decode = {1'b1, 3'd2};
            3'b100:  decode = {1'b1, 3'd3};
            3'b110:  decode = {1'b1, 3'd4};
            default: decode = {1'b0, 3'd0};
        endcase
    endfunction

    always_comb begin
        {cur_legal, cur_idx}   = decode(w_i);
        {prev_legal, prev_idx} = decode(w_prev_q);
        if (x_prev_q) begin
            exp_idx = (prev_idx == 3'd0) ? 3'd4 : prev_idx - 3'd1;
        end else begin
            exp_idx = (prev_idx == 3'd4) ? 3'd0 : prev_idx + 3'd1;
        end
        // An illegal source code can never produce a valid transition.
        check_ok = prev_legal && cur_legal && (cur_idx == exp_idx);
        wrap_fwd = !x_prev_q && (prev_idx == 3'd4) && (cur_idx == 3'd0);
        wrap_rev = x_prev_q && (prev_idx == 3'd0) && (cur_idx == 3'd4);
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        pos_vld_d = pos_vld_q;
        dir_d     = dir_q;
        rev_d     = rev_q;
        wrap_d    = 1'b0;
        err_d     = err_q;
        if (clr_i) begin
            state_d   = StIdle;
            rev_d     = '0;
            err_d     = 1'b0;
            pos_vld_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // First legal code primes the tracker without a transition check.
                    if (cur_legal) begin
                        state_d   = StTrack;
                        pos_d     = cur_idx;
                        pos_vld_d = 1'b1;
                    end else begin
                        state_d   = StFault;
                        err_d     = 1'b1;
                        pos_vld_d = 1'b0;
                    end
                end
                StTrack: begin
                    if (check_ok) begin
                        pos_d = cur_idx;
                        dir_d = x_prev_q;
                        if (wrap_fwd) begin
                            rev_d  = rev_q + REV_W'(1);
                            wrap_d = 1'b1;
                        end else if (wrap_rev) begin
                            rev_d  = rev_q - REV_W'(1);
                            wrap_d = 1'b1;
                        end
                    end else begin
                        state_d   = StFault;
                        err_d     = 1'b1;
                        pos_vld_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = StFault;
                    err_d     = 1'b1;
                    pos_vld_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            w_prev_q  <= 3'b000;
            x_prev_q  <= 1'b0;
            pos_q     <= 3'd0;
            pos_vld_q <= 1'b0;
            dir_q     <= 1'b0;
            rev_q     <= '0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_prev_q  <= w_i;
            x_prev_q  <= x_i;
            pos_q     <= pos_d;
            pos_vld_q <= pos_vld_d;
            dir_q     <= dir_d;
            rev_q     <= rev_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

`ifdef SEQ5_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt_q;
    logic             chk_fail;

    // Checks keep running in FAULT, so repeated bad steps keep counting.
    assign chk_fail = (state_q == StIdle) ? !cur_legal : !check_ok;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_cnt_q <= '0;
        end else if (clr_i) begin
            err_cnt_q <= '0;
        end else if (chk_fail && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign pos_o     = pos_q;
    assign pos_vld_o = pos_vld_q;
    assign dir_o     = dir_q;
    assign rev_o     = rev_q;
    assign wrap_o    = wrap_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_seq5_tracker.sv
module tb_seq5_tracker;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       clr_i = 1'b0;
    logic       x_i = 1'b0;
    logic [2:0] w_i = 3'b000;

    logic [2:0] pos_b, pos_s;
    logic       vld_b, vld_s, dir_b, dir_s, wrap_b, wrap_s, err_b, err_s;
    logic [7:0] rev_b;
    logic [2:0] rev_s;
`ifdef SEQ5_ERR_CNT_EN
    logic [3:0] ecnt_b;
    logic [1:0] ecnt_s;
`endif

    seq5_tracker #(.REV_W(8), .ERR_W(4)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr_i), .x_i(x_i), .w_i(w_i),
        .pos_o(pos_b), .pos_vld_o(vld_b), .dir_o(dir_b), .rev_o(rev_b), .wrap_o(wrap_b),
`ifdef SEQ5_ERR_CNT_EN
        .err_cnt_o(ecnt_b),
`endif
        .err_o(err_b)
    );

    seq5_tracker #(.REV_W(3), .ERR_W(2)) u_dut_small (
        .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr_i), .x_i(x_i), .w_i(w_i),
        .pos_o(pos_s), .pos_vld_o(vld_s), .dir_o(dir_s), .rev_o(rev_s), .wrap_o(wrap_s),
`ifdef SEQ5_ERR_CNT_EN
        .err_cnt_o(ecnt_s),
`endif
        .err_o(err_s)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: positions as integers on a 5-step ring.
    logic [2:0] codes [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110};
    bit  m_primed, m_faulted;
    int  m_pos, m_vld, m_dir, m_rev, m_wrap, m_err, m_ecnt, m_prev, m_xprev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int code_index(input logic [2:0] code);
        for (int i = 0; i < 5; i++) if (codes[i] == code) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_primed = 0; m_faulted = 0; m_pos = 0; m_vld = 0; m_dir = 0; m_rev = 0;
        m_wrap = 0; m_err = 0; m_ecnt = 0; m_prev = 0; m_xprev = 0;
    endtask

    task automatic model_step(input logic x, input logic [2:0] w, input logic clr);
        int idx;
        bit ok;
        idx = code_index(w);
        ok = (m_prev >= 0) && (idx >= 0) && (idx == (m_prev + (m_xprev ? 4 : 1)) % 5);
        m_wrap = 0;
        if (clr) begin
            m_primed = 0; m_faulted = 0; m_rev = 0; m_err = 0; m_vld = 0; m_ecnt = 0;
        end else if (m_faulted) begin
            if (!ok) m_ecnt++;
        end else if (!m_primed) begin
            if (idx >= 0) begin
                m_primed = 1; m_pos = idx; m_vld = 1;
            end else begin
                m_faulted = 1; m_err = 1; m_vld = 0; m_ecnt++;
            end
        end else if (ok) begin
            m_pos = idx;
            m_dir = m_xprev;
            if (!m_xprev && m_prev == 4 && idx == 0) begin m_rev++; m_wrap = 1; end
            if (m_xprev && m_prev == 0 && idx == 4) begin m_rev--; m_wrap = 1; end
        end else begin
            m_faulted = 1; m_err = 1; m_vld = 0; m_ecnt++;
        end
        m_prev = idx;
        m_xprev = x;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] r;
        r = m_rev;
        check_eq({tag, ".pos"},  pos_b,  m_pos);
        check_eq({tag, ".vld"},  vld_b,  m_vld);
        check_eq({tag, ".dir"},  dir_b,  m_dir);
        check_eq({tag, ".rev"},  rev_b,  r & 32'hFF);
        check_eq({tag, ".wrap"}, wrap_b, m_wrap);
        check_eq({tag, ".err"},  err_b,  m_err);
        check_eq({tag, ".s_pos"}, pos_s, m_pos);
        check_eq({tag, ".s_rev"}, rev_s, r & 32'h7);
        check_eq({tag, ".s_wrap"}, wrap_s, m_wrap);
        check_eq({tag, ".s_err"}, err_s, m_err);
`ifdef SEQ5_ERR_CNT_EN
        check_eq({tag, ".ecnt"},   ecnt_b, (m_ecnt > 15) ? 15 : m_ecnt);
        check_eq({tag, ".s_ecnt"}, ecnt_s, (m_ecnt > 3) ? 3 : m_ecnt);
`endif
    endtask

    // Drive one cycle of inputs, model the edge, compare 1 ns after it.
    task automatic step(input string tag, input logic x, input logic [2:0] w, input logic clr);
        x_i = x; w_i = w; clr_i = clr;
        @(posedge clk_i);
        model_step(x, w, clr);
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic reset_mid(input string tag);
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 reset_i = 1'b0;
    endtask

    int wraps;
    logic [2:0] w_rnd;
    logic x_rnd;

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk_i);
        reset_i = 1'b0;

        // Forward revolution.
        step("t1", 0, 3'b000, 0);
        step("t1", 0, 3'b010, 0);
        step("t1", 0, 3'b011, 0);
        step("t1", 0, 3'b100, 0);
        step("t1", 0, 3'b110, 0);
        check_eq("t1_pos4", pos_b, 4);
        step("t1", 1, 3'b000, 0);
        check_eq("t1_wrap", wrap_b, 1);
        check_eq("t1_rev", rev_b, 8'h01);

        // Reverse from 000 after a fresh reset.
        @(posedge clk_i);
        reset_mid("t2_rst");
        step("t2", 1, 3'b000, 0);
        step("t2", 1, 3'b110, 0);
        check_eq("t2_rev_m1", rev_b, 8'hFF);
        check_eq("t2_dir", dir_b, 1);
        foreach (codes[i]) step("t2", 1, codes[(4 - i + 4) % 5 == 0 ? 0 : (4 - i + 4) % 5], 0);
        check_eq("t2_rev_m2", rev_b, 8'hFE);

        // Illegal code injected after 011.
        step("t3", 0, 3'b000, 1);
        step("t3", 0, 3'b000, 0);
        step("t3", 0, 3'b010, 0);
        step("t3", 0, 3'b011, 0);
        step("t3", 0, 3'b101, 0);
        check_eq("t3_err", err_b, 1);
        check_eq("t3_vld", vld_b, 0);
        check_eq("t3_pos", pos_b, 2);
        step("t3", 0, 3'b110, 0);
        step("t3", 0, 3'b000, 0);
        check_eq("t3_sticky", err_b, 1);

        // Clear while faulted and on an illegal code, then prime on 010.
        step("t4", 0, 3'b001, 1);
        check_eq("t4_err", err_b, 0);
        check_eq("t4_rev", rev_b, 0);
        step("t4", 0, 3'b010, 0);
        check_eq("t4_pos", pos_b, 1);
        check_eq("t4_vld", vld_b, 1);

        // Eight forward revolutions on the 3-bit counter.
        @(posedge clk_i);
        reset_mid("t5_rst");
        wraps = 0;
        for (int i = 0; i <= 40; i++) begin
            step("t5", 0, codes[i % 5], 0);
            if (wrap_s) wraps++;
        end
        check_eq("t5_wraps", wraps, 8);
        check_eq("t5_rev_s", rev_s, 0);
        check_eq("t5_rev_b", rev_b, 8);

        // Reset mid-revolution, then repeated stalls saturate the fault count.
        step("t6", 0, 3'b011, 1);
        step("t6", 0, 3'b100, 0);
        check_eq("t6_pos3", pos_b, 3);
        reset_mid("t6_rst");
        step("t6", 0, 3'b000, 0);
        for (int i = 0; i < 10; i++) step("t6", 0, 3'b000, 0);
        check_eq("t6_err", err_s, 1);
`ifdef SEQ5_ERR_CNT_EN
        check_eq("t6_sat_s", ecnt_s, 3);
        check_eq("t6_cnt_b", ecnt_b, 10);
`endif

        // Randomized: mostly a well-behaved counter with occasional faults, clears, resets.
        step("rnd", 0, 3'b000, 1);
        x_rnd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) x_rnd = ~x_rnd;
            if (m_prev >= 0) w_rnd = codes[(m_prev + (m_xprev ? 4 : 1)) % 5];
            else w_rnd = codes[$urandom_range(0, 4)];
            if ($urandom_range(0, 24) == 0) w_rnd = 3'($urandom_range(0, 7));
            step("rnd", x_rnd, w_rnd, ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 199) == 0) reset_mid("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
